// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Defining SSEG_BLANK_EN adds the BLANK state used for inter-digit blanking.
package sseg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

`ifdef SSEG_BLANK_EN
  typedef enum logic [0:0] {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } sseg_state_e;
`else
  typedef enum logic [0:0] {
    SCAN = 1'b0
  } sseg_state_e;
`endif

  function automatic logic [3:0] an_pattern(input logic [1:0] idx);
    logic [3:0] pat;
    unique case (idx)
      2'd0: pat = AN_DIG0;
      2'd1: pat = AN_DIG1;
      2'd2: pat = AN_DIG2;
      2'd3: pat = AN_DIG3;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sseg_prescaler.sv
// Free-running slot/blank prescaler: counts 0..term and pulses tc on the terminal count.
module sseg_prescaler #(
  parameter int unsigned CntW = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [CntW-1:0] term,
  output logic            tc
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tc    = (cnt_q == term);
    cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed display scanner with a double-buffered load interface.
// Defining SSEG_BLANK_EN inserts BLANK_CYC dark cycles after every digit slot.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned CntMax = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam logic [CntW-1:0] TermScan = CntW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || TICK_DIV > (1 << 20)) begin : gen_bad_tick_div
    $error("TICK_DIV out of range");
  end
  if (BLANK_CYC < 1 || BLANK_CYC > 255) begin : gen_bad_blank_cyc
    $error("BLANK_CYC out of range");
  end

  sseg_state_e     state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     active_q, active_d;
  logic [15:0]     shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic [3:0]      an_q, an_d;
  logic [3:0]      digit_q, digit_d;
  logic [CntW-1:0] term;
  logic            tc;
  logic            slot_end;
  logic            frame_end;
  logic            accept;

`ifdef SSEG_BLANK_EN
  localparam logic [CntW-1:0] TermBlank = CntW'(BLANK_CYC - 1);
  assign term = (state_q == BLANK) ? TermBlank : TermScan;
`else
  assign term = TermScan;
`endif

  sseg_prescaler #(
    .CntW (CntW)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .term  (term),
    .tc    (tc)
  );

  assign slot_end  = (state_q == SCAN) && tc;
  assign frame_end = slot_end && (idx_q == 2'd3);
  assign accept    = load_valid && !pending_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef SSEG_BLANK_EN
    if (tc) begin
      if (state_q == SCAN) begin
        state_d = BLANK;
      end else begin
        state_d = SCAN;
        idx_d   = idx_q + 2'd1;
      end
    end
`else
    if (tc) begin
      idx_d = idx_q + 2'd1;
    end
`endif
  end

  // Swap only on the frame boundary so a frame never mixes old and new digits;
  // a word accepted in that same cycle waits for the following boundary.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    an_d    = AN_OFF;
    digit_d = digit_q;
    if (state_q == SCAN) begin
      an_d    = an_pattern(idx_q);
      digit_d = active_q[{idx_q, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= SCAN;
      idx_q     <= 2'd0;
      active_q  <= 16'h0000;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
      an_q      <= AN_OFF;
      digit_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      digit_q   <= digit_d;
    end
  end

  assign an         = an_q;
  assign digit      = digit_q;
  assign load_ready = ~pending_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl (TICK_DIV=4, BLANK_CYC=2); honours SSEG_BLANK_EN.
module tb_sseg_scan_ctrl;

  localparam int TD = 4;
  localparam int BC = 2;
`ifdef SSEG_BLANK_EN
  localparam int L = TD + BC;
`else
  localparam int L = TD;
`endif
  localparam int PERIOD = 4 * L;

  logic        clock;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_done;

  sseg_scan_ctrl #(
    .TICK_DIV  (TD),
    .BLANK_CYC (BC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .digit      (digit),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: k counts internal cycles since reset release.
  int          k;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  bit          m_pend;
  logic [3:0]  exp_an;
  logic [3:0]  exp_digit;

  function automatic int slot_of(input int kk);
    return (kk % PERIOD) / L;
  endfunction

  function automatic bit in_scan(input int kk);
    return ((kk % PERIOD) % L) < TD;
  endfunction

  function automatic bit boundary(input int kk);
    return (kk % PERIOD) == (3 * L + TD - 1);
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(9));
    return w;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s at k=%0d: observed %h expected %h", tag, k, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    check("an", {12'h0, an}, {12'h0, exp_an});
    check("digit", {12'h0, digit}, {12'h0, exp_digit});
    check("load_ready", {15'h0, load_ready}, {15'h0, !m_pend});
    check("frame_done", {15'h0, frame_done}, {15'h0, boundary(k)});
    check("an_multi_hot", 16'($countones(~an) <= 1), 16'h1);
  endtask

  task automatic model_reset();
    k         = 0;
    m_active  = 16'h0;
    m_shadow  = 16'h0;
    m_pend    = 0;
    exp_an    = 4'hF;
    exp_digit = 4'h0;
  endtask

  task automatic step(input bit v, input logic [15:0] d);
    bit acc;
    check_outputs();
    load_valid = v;
    load_data  = d;
    @(posedge clock);
    #1;
    if (in_scan(k)) begin
      exp_an    = 4'hF ^ (4'h1 << slot_of(k));
      exp_digit = 4'(m_active >> (4 * slot_of(k)));
    end else begin
      exp_an = 4'hF;
    end
    acc = v && !m_pend;
    if (boundary(k) && m_pend) begin
      m_active = m_shadow;
      m_pend   = 0;
    end
    if (acc) begin
      m_shadow = d;
      m_pend   = 1;
    end
    k++;
  endtask

  task automatic do_reset(input int n);
    reset      = 1'b1;
    load_valid = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    check_outputs();
    repeat (n - 1) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;
    model_reset();
    do_reset(3);

    // Idle scan straight out of reset.
    repeat (PERIOD + 4) step(0, 16'h0);

    // Load at cycle 2, then a second offer while pending that must be ignored.
    do_reset(2);
    step(0, 16'h0);
    step(0, 16'h0);
    step(1, 16'h4321);
    step(1, 16'h9999);
    repeat (3 * PERIOD) step(0, 16'h0);

    // Load offered exactly in the frame-boundary cycle with nothing pending.
    guard = 0;
    while (!(boundary(k) && !m_pend) && guard < 4 * PERIOD) begin
      step(0, 16'h0);
      guard++;
    end
    check("wait_boundary_timeout", 16'(guard < 4 * PERIOD), 16'h1);
    step(1, 16'h5678);
    repeat (2 * PERIOD + 2) step(0, 16'h0);

    // Random traffic.
    repeat (400) step($urandom_range(7) == 0, rand_bcd());

    // Reset during the digit2 slot with a word pending.
    guard = 0;
    while (!(slot_of(k) == 0 && !m_pend) && guard < 4 * PERIOD) begin
      step(0, 16'h0);
      guard++;
    end
    check("wait_slot0_timeout", 16'(guard < 4 * PERIOD), 16'h1);
    step(1, 16'h8765);
    guard = 0;
    while (!(slot_of(k) == 2 && in_scan(k)) && guard < 4 * PERIOD) begin
      step(0, 16'h0);
      guard++;
    end
    check("pending_before_reset", {15'h0, load_ready}, 16'h0);
    do_reset(1);
    repeat (2 * PERIOD + 2) step(0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
